// File: rtl/sync_multi_rx.sv
// rtl/sync_multi_rx.sv - multi-channel four-phase handshake receiver with round-robin capture
// Optional sticky withdrawal flags: define SYNC_MULTI_RX_ERR_EN.
module sync_multi_rx #(
    parameter int DATA_WIDTH  = 8,
    parameter int NCH         = 4,
    parameter int SYNC_STAGES = 2,
    parameter int CH_W        = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic                      clk_rx,
    input  logic                      reset,
    input  logic [NCH-1:0]            req_in,
    input  logic [NCH*DATA_WIDTH-1:0] data_in,
    output logic [NCH-1:0]            ack_out,
    output logic [DATA_WIDTH-1:0]     out_data,
    output logic [CH_W-1:0]           out_ch,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [NCH-1:0]            err,
    input  logic                      err_clr
);

    typedef enum logic {IDLE = 1'b0, ACKH = 1'b1} ch_state_e;

    ch_state_e               state_q [NCH];
    ch_state_e               state_d [NCH];
    logic [NCH-1:0]          sync_q [SYNC_STAGES];
    logic [NCH-1:0]          req_s, req_d_q, eligible, withdraw;
    logic [DATA_WIDTH-1:0]   out_data_q, out_data_d;
    logic [CH_W-1:0]         out_ch_q, out_ch_d, rr_q, rr_d, grant_idx;
    logic                    out_valid_q, out_valid_d, out_free, grant_hit, grant;

    assign req_s = sync_q[SYNC_STAGES-1];

    always_ff @(posedge clk_rx or negedge reset) begin
        if (!reset) begin
            for (int s = 0; s < SYNC_STAGES; s++) sync_q[s] <= '0;
            req_d_q <= '0;
        end else begin
            sync_q[0] <= req_in;
            for (int s = 1; s < SYNC_STAGES; s++) sync_q[s] <= sync_q[s-1];
            req_d_q <= req_s;
        end
    end

    // Round-robin search starting at rr_q; the first eligible channel wins.
    always_comb begin
        int idx;
        idx       = 0;
        grant_hit = 1'b0;
        grant_idx = '0;
        out_free  = !out_valid_q || out_ready;
        for (int i = 0; i < NCH; i++) begin
            eligible[i] = (state_q[i] == IDLE) && req_s[i];
            withdraw[i] = (state_q[i] == IDLE) && req_d_q[i] && !req_s[i];
        end
        for (int k = 0; k < NCH; k++) begin
            idx = (int'(rr_q) + k) % NCH;
            if (!grant_hit && eligible[idx]) begin
                grant_hit = 1'b1;
                grant_idx = CH_W'(idx);
            end
        end
        grant = out_free && grant_hit;
    end

    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_ch_d    = out_ch_q;
        rr_d        = rr_q;
        for (int i = 0; i < NCH; i++) begin
            state_d[i] = state_q[i];
            if (state_q[i] == ACKH && !req_s[i]) state_d[i] = IDLE;
            if (grant && grant_idx == CH_W'(i)) state_d[i] = ACKH;
        end
        if (grant) begin
            out_valid_d = 1'b1;
            out_data_d  = data_in[int'(grant_idx)*DATA_WIDTH +: DATA_WIDTH];
            out_ch_d    = grant_idx;
            rr_d        = CH_W'((int'(grant_idx) + 1) % NCH);
        end else if (out_free) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk_rx or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NCH; i++) state_q[i] <= IDLE;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_ch_q    <= '0;
            rr_q        <= '0;
        end else begin
            for (int i = 0; i < NCH; i++) state_q[i] <= state_d[i];
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_ch_q    <= out_ch_d;
            rr_q        <= rr_d;
        end
    end

    always_comb begin
        for (int i = 0; i < NCH; i++) ack_out[i] = (state_q[i] == ACKH);
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_ch    = out_ch_q;

`ifdef SYNC_MULTI_RX_ERR_EN
    logic [NCH-1:0] err_q, err_d;

    // A withdrawal on the same edge as err_clr must still be recorded.
    always_comb begin
        err_d = err_clr ? '0 : err_q;
        err_d = err_d | withdraw;
    end

    always_ff @(posedge clk_rx or negedge reset) begin
        if (!reset) err_q <= '0;
        else        err_q <= err_d;
    end

    assign err = err_q;
`else
    logic [NCH:0] unused_err_sink;
    assign unused_err_sink = {err_clr, withdraw};
    assign err = '0;
`endif

endmodule

// File: tb/tb_sync_multi_rx.sv
// tb/tb_sync_multi_rx.sv - self-checking bench for sync_multi_rx
module tb_sync_multi_rx;
    localparam int DW  = 8;
    localparam int NCH = 4;
    localparam int SS  = 2;
    localparam int CW  = 2;

    logic              clk_rx = 1'b0;
    logic              reset  = 1'b0;
    logic [NCH-1:0]    req_in;
    logic [NCH*DW-1:0] data_in;
    logic [NCH-1:0]    ack_out;
    logic [DW-1:0]     out_data;
    logic [CW-1:0]     out_ch;
    logic              out_valid;
    logic              out_ready;
    logic [NCH-1:0]    err;
    logic              err_clr;

    int n_checks = 0;
    int n_fail   = 0;

    sync_multi_rx #(.DATA_WIDTH(DW), .NCH(NCH), .SYNC_STAGES(SS)) dut (
        .clk_rx(clk_rx), .reset(reset), .req_in(req_in), .data_in(data_in),
        .ack_out(ack_out), .out_data(out_data), .out_ch(out_ch),
        .out_valid(out_valid), .out_ready(out_ready), .err(err), .err_clr(err_clr)
    );

    always #5 clk_rx = ~clk_rx;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk_rx);
        #2;
    endtask

    // Model: req_s seen before edge E is the req_in sample taken SS edges earlier.
    logic [NCH-1:0] smp [1:SS+1];
    logic [NCH-1:0] m_ack, m_err, m_rs, m_rd, m_wd, m_old;
    logic           m_valid, m_free;
    logic [DW-1:0]  m_data;
    int             m_ch, m_rr, m_gnt, m_c;

    always @(posedge clk_rx or negedge reset) begin
        if (!reset) begin
            for (int k = 1; k <= SS + 1; k++) smp[k] = '0;
            m_ack = '0; m_err = '0; m_valid = 1'b0; m_data = '0; m_ch = 0; m_rr = 0;
        end else begin
            m_rs   = smp[SS];
            m_rd   = smp[SS+1];
            m_old  = m_ack;
            m_free = !m_valid || out_ready;
            m_wd   = ~m_old & m_rd & ~m_rs;
            m_ack  = m_old & m_rs;
            m_gnt  = -1;
            if (m_free) begin
                for (int k = 0; k < NCH; k++) begin
                    m_c = (m_rr + k) % NCH;
                    if (m_gnt < 0 && !m_old[m_c] && m_rs[m_c]) m_gnt = m_c;
                end
            end
            if (m_gnt >= 0) begin
                m_ack[m_gnt] = 1'b1;
                m_valid = 1'b1;
                m_data  = data_in[m_gnt*DW +: DW];
                m_ch    = m_gnt;
                m_rr    = (m_gnt + 1) % NCH;
            end else if (m_free) begin
                m_valid = 1'b0;
            end
`ifdef SYNC_MULTI_RX_ERR_EN
            if (err_clr) m_err = '0;
            m_err = m_err | m_wd;
`endif
            for (int k = SS + 1; k >= 2; k--) smp[k] = smp[k-1];
            smp[1] = req_in;
        end
    end

    always @(negedge clk_rx) begin
        if (reset) begin
            chk("model_ack_out", 32'(ack_out), 32'(m_ack));
            chk("model_out_valid", 32'(out_valid), 32'(m_valid));
            chk("model_out_data", 32'(out_data), 32'(m_data));
            chk("model_out_ch", 32'(out_ch), 32'(m_ch));
            chk("model_err", 32'(err), 32'(m_err));
        end
    end

    logic [NCH-1:0] exp_err;
    logic [9:0]     ready_pat;

    initial begin
        req_in = '0; data_in = '0; out_ready = 1'b1; err_clr = 1'b0; reset = 1'b0;
        step(3);
        reset = 1'b1;
        chk("rst_ack", 32'(ack_out), 32'h0);
        chk("rst_valid", 32'(out_valid), 32'h0);
        chk("rst_data", 32'(out_data), 32'h0);
        chk("rst_ch", 32'(out_ch), 32'h0);
        chk("rst_err", 32'(err), 32'h0);

        // Single channel: grant exactly at E0+2, release 2 edges after first low sample
        data_in = 32'h000000A5; req_in = 4'b0001;
        step(2);
        chk("s1_ack_not_early", 32'(ack_out), 32'h0);
        step(1);
        chk("s1_ack", 32'(ack_out), 32'h1);
        chk("s1_valid", 32'(out_valid), 32'h1);
        chk("s1_data", 32'(out_data), 32'hA5);
        chk("s1_ch", 32'(out_ch), 32'h0);
        req_in = 4'b0000;
        step(2);
        chk("s1_ack_hold", 32'(ack_out), 32'h1);
        step(1);
        chk("s1_ack_fall", 32'(ack_out), 32'h0);
        step(2);

        reset = 1'b0; step(1); reset = 1'b1;

        // Simultaneous ch1/ch3 with rr=0
        data_in = 32'h33001100; req_in = 4'b1010;
        step(3);
        chk("s2_first_ack", 32'(ack_out), 32'h2);
        chk("s2_first_ch", 32'(out_ch), 32'h1);
        chk("s2_first_data", 32'(out_data), 32'h11);
        step(1);
        chk("s2_second_ack", 32'(ack_out), 32'hA);
        chk("s2_second_ch", 32'(out_ch), 32'h3);
        chk("s2_second_data", 32'(out_data), 32'h33);
        chk("s2_second_valid", 32'(out_valid), 32'h1);
        step(1);
        chk("s2_drained", 32'(out_valid), 32'h0);
        req_in = 4'b0000;
        step(4);

        // Backpressure
        out_ready = 1'b0;
        data_in = 32'h00220000; req_in = 4'b0100;
        step(3);
        chk("s3_ch2_ch", 32'(out_ch), 32'h2);
        chk("s3_ch2_valid", 32'(out_valid), 32'h1);
        data_in = 32'h0022000A; req_in = 4'b0101;
        step(4);
        chk("s3_stall_valid", 32'(out_valid), 32'h1);
        chk("s3_stall_data", 32'(out_data), 32'h22);
        chk("s3_stall_ch", 32'(out_ch), 32'h2);
        chk("s3_stall_ack", 32'(ack_out), 32'h4);
        out_ready = 1'b1;
        step(1);
        chk("s3_swap_data", 32'(out_data), 32'h0A);
        chk("s3_swap_ch", 32'(out_ch), 32'h0);
        chk("s3_swap_valid", 32'(out_valid), 32'h1);
        chk("s3_swap_ack", 32'(ack_out), 32'h5);
        req_in = 4'b0000;
        step(5);

        // Withdrawal while output stalled
        out_ready = 1'b0;
        data_in = 32'h00005500; req_in = 4'b0010;
        step(3);
        chk("s4_fill_ch", 32'(out_ch), 32'h1);
        data_in = 32'h00775500; req_in = 4'b0110;
        step(3);
        req_in = 4'b0010;
        step(3);
`ifdef SYNC_MULTI_RX_ERR_EN
        exp_err = 4'b0100;
`else
        exp_err = 4'b0000;
`endif
        chk("s4_err_set", 32'(err), 32'(exp_err));
        chk("s4_no_ack2", 32'(ack_out), 32'h2);
        err_clr = 1'b1;
        step(1);
        err_clr = 1'b0;
        chk("s4_err_clr", 32'(err), 32'h0);
        out_ready = 1'b1;
        step(1);
        chk("s4_no_ch2_word", 32'(out_valid), 32'h0);
        req_in = 4'b0000;
        step(4);

        // All channels requesting under a ready pattern
        data_in = 32'h43424140; req_in = 4'b1111;
        ready_pat = 10'b1101101011;
        for (int i = 0; i < 10; i++) begin
            out_ready = ready_pat[i];
            step(1);
        end
        out_ready = 1'b1; req_in = 4'b0000;
        step(5);

        // Reset mid-handshake
        out_ready = 1'b0;
        data_in = 32'h00009900; req_in = 4'b0010;
        step(3);
        chk("s6_pre_ack", 32'(ack_out), 32'h2);
        chk("s6_pre_valid", 32'(out_valid), 32'h1);
        reset = 1'b0;
        #1;
        chk("s6_async_ack", 32'(ack_out), 32'h0);
        chk("s6_async_valid", 32'(out_valid), 32'h0);
        chk("s6_async_data", 32'(out_data), 32'h0);
        chk("s6_async_ch", 32'(out_ch), 32'h0);
        chk("s6_async_err", 32'(err), 32'h0);
        req_in = 4'b0000;
        step(2);
        reset = 1'b1;
        step(3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
